fdiv_newton: RTL and testbench

Iterative IEEE-754 single-precision divider (s = a / b) using Newton–Raphson reciprocal refinement. It sits in the FPU execute path. While a divide is in flight it raises `stall` to freeze the issuing pipeline, and it exposes its iteration counter and current reciprocal estimate for debug.

---
 rtl/fdiv_newton_if.sv | 20 ++
 rtl/fdiv_newton.sv | 237 +++++++++++++++++++++++
 tb/tb_fdiv_newton.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fdiv_newton_if.sv
// Handshake/bus bundle for the fdiv_newton divider.
// master: issuing FPU pipeline (drives operands, rm, fdiv, ena; observes result/debug/stall).
// slave : the divider (consumes operands, produces s, reg_x, count, busy, stall).
interface fdiv_newton_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  rm;
  logic        fdiv;
  logic        ena;
  logic [31:0] s;
  logic [25:0] reg_x;
  logic [4:0]  count;
  logic        busy;
  logic        stall;

  modport master (output a, b, rm, fdiv, ena,
                  input  s, reg_x, count, busy, stall);
  modport slave  (input  a, b, rm, fdiv, ena,
                  output s, reg_x, count, busy, stall);
endinterface

// File: rtl/fdiv_newton.sv
// Iterative IEEE-754 single divider s = a/b via Newton-Raphson reciprocal, correctly rounded for all rm.
// Latency: s written 9 clocks after the start edge (start edge counted); one-cycle done follows, then idle.
// Backpressure: stall = fdiv & ~done freezes the issuer; ena=0 holds every register and blocks start.
// Ports: clk, clrn (synchronous active-high reset), bus (slave: a, b, rm, fdiv, ena in; s, reg_x, count, busy, stall out).
module fdiv_newton (
  input  logic         clk,
  input  logic         clrn,
  fdiv_newton_if.slave bus
);

  localparam logic [1:0] SPEC_NONE = 2'd0;
  localparam logic [1:0] SPEC_NAN  = 2'd1;
  localparam logic [1:0] SPEC_INF  = 2'd2;
  localparam logic [1:0] SPEC_ZERO = 2'd3;

  // Seed ROM: entry i holds the 8 bits below the leading 1 of 1/m, m the midpoint
  // of the significand interval [1+i/256, 1+(i+1)/256), rounded to 9 bits.
  function automatic logic [2047:0] gen_seed_rom();
    logic [2047:0] rom;
    int den;
    rom = '0;
    for (int i = 0; i < 256; i++) begin
      den = 513 + 2 * i;
      rom[i*8 +: 8] = 8'((2 * 262144 + den) / (2 * den) - 256);
    end
    return rom;
  endfunction

  localparam logic [2047:0] SEED_ROM = gen_seed_rom();

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  state_t state, state_next;

  // ---------------- unpack of the incoming operands ----------------
  logic [7:0]         ea_f, eb_f;
  logic [22:0]        fa, fb;
  logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [4:0]         lza, lzb;
  logic [23:0]        ma_in, mb_in;
  logic signed [10:0] ea_in, eb_in, exp_in;
  logic [1:0]         spec_in;
  logic [7:0]         seed;
  logic               start;

  assign ea_f   = bus.a[30:23];
  assign eb_f   = bus.b[30:23];
  assign fa     = bus.a[22:0];
  assign fb     = bus.b[22:0];
  assign a_zero = (ea_f == 8'd0)   && (fa == 23'd0);
  assign b_zero = (eb_f == 8'd0)   && (fb == 23'd0);
  assign a_inf  = (ea_f == 8'hFF)  && (fa == 23'd0);
  assign b_inf  = (eb_f == 8'hFF)  && (fb == 23'd0);
  assign a_nan  = (ea_f == 8'hFF)  && (fa != 23'd0);
  assign b_nan  = (eb_f == 8'hFF)  && (fb != 23'd0);
  assign lza    = lzc24({1'b0, fa});
  assign lzb    = lzc24({1'b0, fb});

  // Denormals are shifted up to 1.xx and their exponent lowered by the same amount.
  assign ma_in  = (ea_f != 8'd0) ? {1'b1, fa} : ({1'b0, fa} << lza);
  assign mb_in  = (eb_f != 8'd0) ? {1'b1, fb} : ({1'b0, fb} << lzb);
  assign ea_in  = (ea_f != 8'd0) ? $signed({3'b000, ea_f}) : (11'sd1 - $signed({6'd0, lza}));
  assign eb_in  = (eb_f != 8'd0) ? $signed({3'b000, eb_f}) : (11'sd1 - $signed({6'd0, lzb}));
  assign exp_in = ea_in - eb_in + 11'sd127;
  assign seed   = SEED_ROM[{mb_in[22:15], 3'b000} +: 8];

  always_comb begin
    spec_in = SPEC_NONE;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spec_in = SPEC_NAN;
    else if (a_inf || b_zero)                                     spec_in = SPEC_INF;
    else if (a_zero || b_inf)                                     spec_in = SPEC_ZERO;
  end

  // ---------------- operation registers ----------------
  logic               sign_r;
  logic [23:0]        ma_r, mb_r;
  logic signed [10:0] exp_r;
  logic [1:0]         spec_r, rm_r;
  logic [25:0]        x_r, t_r, qe_r;
  logic [4:0]         count_r;
  logic [31:0]        s_r;

  assign start = bus.fdiv && bus.ena && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (clrn) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (bus.ena && count_r == 5'd8) state_next = ST_DONE;
      ST_DONE: if (bus.ena) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- iteration datapath ----------------
  // Dividend is pre-doubled when ma < mb so the quotient always lands in [1,2).
  logic        ge;
  logic [24:0] num;
  logic [25:0] t_next, x_next, qe_next;

  assign ge      = (ma_r >= mb_r);
  assign num     = ge ? {1'b0, ma_r} : {ma_r, 1'b0};
  // t = 2 - mb*x : product is 2.48, keep 1.25
  assign t_next  = 26'(((50'd1 << 49) - 50'(mb_r) * 50'(x_r)) >> 23);
  // x = x*t : product is 2.50, keep 1.25
  assign x_next  = 26'((52'(x_r) * 52'(t_r)) >> 25);
  // q = num*x : product weight 2^-48, keep weight 2^-25 (26 bits: 1 + 23 frac + guard + round)
  assign qe_next = 26'((51'(num) * 51'(x_r)) >> 23);

  // ---------------- correction, rounding, packing ----------------
  // Truncation makes x <= 1/mb, so qe never exceeds the true quotient and the
  // remainder is non-negative and a few mb at most; the compare ladder finds the
  // exact floor, leaving the true remainder for the sticky bit.
  logic [49:0]        r0, rem;
  logic [3:0]         d;
  logic [25:0]        qi, qs;
  logic signed [10:0] e_q, e_fin;
  logic [4:0]         sh_amt;
  logic [52:0]        wide;
  logic [23:0]        m24;
  logic [24:0]        m25;
  logic [22:0]        frac;
  logic               g, st, inc;
  logic [31:0]        result;

  always_comb begin
    r0 = {num, 25'd0} - (50'(qe_r) * 50'(mb_r));
    d  = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (r0 >= 50'(mb_r) * 50'(k)) d = 4'(k);
    end
    rem = r0 - 50'(mb_r) * 50'(d);
    qi  = qe_r + 26'(d);

    e_q    = exp_r - (ge ? 11'sd0 : 11'sd1);
    sh_amt = 5'd0;
    if (e_q < 11'sd1) sh_amt = (e_q < -11'sd26) ? 5'd27 : 5'(11'sd1 - e_q);
    // Below the normal range the significand slides right into a denormal;
    // everything shifted out joins the sticky bit.
    wide = {qi, 27'd0} >> sh_amt;
    qs   = wide[52:27];
    m24  = qs[25:2];
    g    = qs[1];
    st   = qs[0] | (|wide[26:0]) | (rem != 50'd0);

    unique case (rm_r)
      2'b00:   inc = g & (st | m24[0]);
      2'b01:   inc = sign_r & (g | st);
      2'b10:   inc = ~sign_r & (g | st);
      default: inc = 1'b0;
    endcase
    m25 = {1'b0, m24} + {24'd0, inc};

    if (e_q < 11'sd1) begin
      // a denormal that rounds up into bit 23 becomes the smallest normal
      e_fin = {10'd0, m25[23]};
      frac  = m25[22:0];
    end else if (m25[24]) begin
      e_fin = e_q + 11'sd1;
      frac  = 23'd0;
    end else begin
      e_fin = e_q;
      frac  = m25[22:0];
    end

    result = {sign_r, e_fin[7:0], frac};
    if (e_fin >= 11'sd255) begin
      unique case (rm_r)
        2'b00:   result = {sign_r, 8'hFF, 23'd0};
        2'b01:   result = sign_r ? {1'b1, 8'hFF, 23'd0} : {1'b0, 8'hFE, 23'h7FFFFF};
        2'b10:   result = sign_r ? {1'b1, 8'hFE, 23'h7FFFFF} : {1'b0, 8'hFF, 23'd0};
        default: result = {sign_r, 8'hFE, 23'h7FFFFF};
      endcase
    end

    unique case (spec_r)
      SPEC_NAN:  result = 32'h7FC00000;
      SPEC_INF:  result = {sign_r, 8'hFF, 23'd0};
      SPEC_ZERO: result = {sign_r, 31'd0};
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      count_r <= 5'd0;
      x_r     <= 26'd0;
      t_r     <= 26'd0;
      qe_r    <= 26'd0;
      s_r     <= 32'd0;
      sign_r  <= 1'b0;
      ma_r    <= 24'd0;
      mb_r    <= 24'd0;
      exp_r   <= 11'sd0;
      spec_r  <= SPEC_NONE;
      rm_r    <= 2'd0;
    end else if (start) begin
      sign_r  <= bus.a[31] ^ bus.b[31];
      ma_r    <= ma_in;
      mb_r    <= mb_in;
      exp_r   <= exp_in;
      spec_r  <= spec_in;
      rm_r    <= bus.rm;
      x_r     <= {2'b01, seed, 16'd0};
      count_r <= 5'd1;
    end else if (bus.ena && state == ST_RUN) begin
      case (count_r)
        5'd1, 5'd3, 5'd5: t_r  <= t_next;
        5'd2, 5'd4, 5'd6: x_r  <= x_next;
        5'd7:             qe_r <= qe_next;
        5'd8:             s_r  <= result;
        default:          ;
      endcase
      count_r <= (count_r == 5'd8) ? 5'd0 : count_r + 5'd1;
    end
  end

  assign bus.s     = s_r;
  assign bus.reg_x = x_r;
  assign bus.count = count_r;
  assign bus.busy  = (state == ST_RUN);
  assign bus.stall = bus.fdiv & (state != ST_DONE);

endmodule

// File: tb/tb_fdiv_newton.sv
// Directed self-checking bench for fdiv_newton: reset state, latency/stall timing,
// rounding modes, denormals, specials, range limits, ena freeze and mid-op reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fdiv_newton;
  logic clk = 1'b0;
  logic clrn;
  int   n_checks = 0;
  int   n_pass   = 0;

  fdiv_newton_if bus ();

  fdiv_newton u_dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm;
    logic [31:0] want;
  } vec_t;

  vec_t vecs [0:16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
  endtask

  // Raise fdiv with the given operands and follow the op to its done cycle.
  // pause>0 drops ena for that many cycles once count reaches 4.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rm, input logic [31:0] want, input int pause);
    int cyc;
    bit paused;
    bus.a    = a;
    bus.b    = b;
    bus.rm   = rm;
    bus.fdiv = 1'b1;
    #1;
    check({tag, ".stall_start"}, 32'(bus.stall), 32'd1);
    cyc    = 0;
    paused = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.count == 5'd8) check({tag, ".stall_c8"}, 32'(bus.stall), 32'd1);
      if (pause > 0 && !paused && bus.count == 5'd4) begin
        bus.ena = 1'b0;
        repeat (pause) begin
          @(negedge clk);
          cyc++;
        end
        check({tag, ".frozen_count"}, 32'(bus.count), 32'd4);
        bus.ena = 1'b1;
        paused  = 1'b1;
      end
      if (!bus.busy) break;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(9 + pause));
    check({tag, ".stall_done"}, 32'(bus.stall), 32'd0);
    check({tag, ".s"}, bus.s, want);
  endtask

  task automatic idle();
    bus.fdiv = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    clrn     = 1'b1;
    bus.a    = 32'd0;
    bus.b    = 32'd0;
    bus.rm   = 2'd0;
    bus.fdiv = 1'b0;
    bus.ena  = 1'b1;

    vecs = '{
      '{32'h0000FE01, 32'h000000FF, 2'd0, 32'h437F0000},
      '{32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB},
      '{32'h3F800000, 32'h40400000, 2'd3, 32'h3EAAAAAA},
      '{32'h3F800000, 32'h40400000, 2'd2, 32'h3EAAAAAB},
      '{32'h3F800000, 32'h40400000, 2'd1, 32'h3EAAAAAA},
      '{32'hBF800000, 32'h40400000, 2'd1, 32'hBEAAAAAB},
      '{32'hBF800000, 32'h40400000, 2'd2, 32'hBEAAAAAA},
      '{32'h3F800000, 32'h00000000, 2'd0, 32'h7F800000},
      '{32'hBF800000, 32'h00000000, 2'd0, 32'hFF800000},
      '{32'h00000000, 32'h00000000, 2'd0, 32'h7FC00000},
      '{32'h3F800000, 32'h7F800000, 2'd0, 32'h00000000},
      '{32'h7FC00000, 32'h40000000, 2'd0, 32'h7FC00000},
      '{32'h7F7FFFFF, 32'h3E800000, 2'd0, 32'h7F800000},
      '{32'h7F7FFFFF, 32'h3E800000, 2'd3, 32'h7F7FFFFF},
      '{32'h7F7FFFFF, 32'h3E800000, 2'd2, 32'h7F800000},
      '{32'h7F7FFFFF, 32'h3E800000, 2'd1, 32'h7F7FFFFF},
      '{32'h00800000, 32'h40000000, 2'd0, 32'h00400000}
    };

    repeat (3) @(negedge clk);
    check("rst.s",     bus.s,               32'd0);
    check("rst.reg_x", 32'(bus.reg_x),      32'd0);
    check("rst.count", 32'(bus.count),      32'd0);
    check("rst.busy",  32'(bus.busy),       32'd0);
    check("rst.stall", 32'(bus.stall),      32'd0);
    clrn = 1'b0;
    @(negedge clk);

    // 8/4 with fdiv held high: a second op follows right after done.
    run_div("div8_4", 32'h41000000, 32'h40800000, 2'd0, 32'h40000000, 0);
    @(negedge clk);
    check("b2b.gap_busy",  32'(bus.busy),  32'd0);
    check("b2b.gap_stall", 32'(bus.stall), 32'd1);
    run_div("div8_4_b2b", 32'h41000000, 32'h40800000, 2'd0, 32'h40000000, 0);
    idle();

    for (int i = 0; i < 17; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].rm, vecs[i].want, 0);
      idle();
    end

    // ena low for 3 cycles at count 4: latency 12, same quotient
    run_div("ena_pause", 32'h3F800000, 32'h40400000, 2'd0, 32'h3EAAAAAB, 3);
    idle();

    // reset asserted at count 5 aborts the op
    bus.a    = 32'h3F800000;
    bus.b    = 32'h40400000;
    bus.rm   = 2'd0;
    bus.fdiv = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.count == 5'd5) break;
    end
    check("midrst.reach5", 32'(bus.count), 32'd5);
    clrn = 1'b1;
    @(negedge clk);
    check("midrst.busy",  32'(bus.busy),  32'd0);
    check("midrst.count", 32'(bus.count), 32'd0);
    check("midrst.reg_x", 32'(bus.reg_x), 32'd0);
    clrn = 1'b0;
    idle();

    run_div("after_rst", 32'h41000000, 32'h40800000, 2'd0, 32'h40000000, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
